// File: rtl/ex_alu_seq.sv
// ex_alu_seq: EX-stage ALU. Logic, arithmetic, compare and pass-through ops finish in one cycle.
//   Shifts use an iterative shifter that moves one bit per cycle.
// Latency: 1 cycle for non-shift ops, illegal codes and zero-amount shifts; k cycles for shifts by k >= 1.
// Backpressure: out_ready low holds DONE with result/zero/illegal stable, and in_ready stays low.
//   flush abandons any in-flight op and returns the block to IDLE.
// Ports: clk/rst (sync, active-high); in_valid/in_ready with alu_ctrl, op_a, op_b;
//   flush; out_valid/out_ready with result, zero, illegal.
module ex_alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   cnt;
    logic [1:0]      sh_kind;   // alu_ctrl[1:0] of the shift in flight: 01 SLL, 10 SRL, 11 SRA
    logic            accept;
    logic            is_shift;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res;
    logic            lt_s;
    logic            lt_u;

    // Shift by one bit in the direction and fill mode selected by kind.
    function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] val, input logic [1:0] kind);
        logic [XLEN-1:0] r;
        case (kind)
            2'b01:   r = {val[XLEN-2:0], 1'b0};
            2'b10:   r = {1'b0, val[XLEN-1:1]};
            2'b11:   r = {val[XLEN-1], val[XLEN-1:1]};
            default: r = val;
        endcase
        return r;
    endfunction

    assign accept   = in_valid && in_ready && !flush;
    assign shamt    = op_b[SW-1:0];
    assign is_shift = (alu_ctrl == 4'd5) || (alu_ctrl == 4'd6) || (alu_ctrl == 4'd7);
    assign lt_s     = $signed(op_a) < $signed(op_b);
    assign lt_u     = op_a < op_b;

    // Result captured at the accept edge. For a shift this already includes the first bit step.
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            4'd0:  alu_res = op_a + op_b;
            4'd1:  alu_res = op_a - op_b;
            4'd2:  alu_res = op_a & op_b;
            4'd3:  alu_res = op_a | op_b;
            4'd4:  alu_res = op_a ^ op_b;
            4'd5, 4'd6, 4'd7:
                   alu_res = (shamt == '0) ? op_a : shift1(op_a, alu_ctrl[1:0]);
            4'd8:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            4'd9:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
            4'd10: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. flush overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (is_shift && (shamt > SW'(1))) ? SHIFT : DONE;
                end
            end
            // cnt holds the number of bit steps still to do. The step taken at cnt == 1 is the last one.
            SHIFT: begin
                if (cnt <= SW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // Output logic
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        zero      = (result == '0);
    end

    // Datapath registers. On flush they keep whatever they hold, because out_valid is already low.
    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            illegal <= 1'b0;
            cnt     <= '0;
            sh_kind <= 2'b00;
        end else if (accept) begin
            result  <= alu_res;
            illegal <= (alu_ctrl > 4'd10);
            sh_kind <= alu_ctrl[1:0];
            cnt     <= (is_shift && (shamt != '0)) ? (shamt - SW'(1)) : '0;
        end else if ((state == SHIFT) && !flush) begin
            result <= shift1(result, sh_kind);
            cnt    <= cnt - SW'(1);
        end
    end

endmodule
